// File: rtl/integrate_dump_pkg.sv
// Shared types and constants for the integrate-and-dump stage.
// Holds the FSM state type, default sizing, and the saturation limits for a given width.
package integrate_dump_pkg;

    typedef enum logic {
        WAIT_EPOCH = 1'b0,
        INTEGRATE  = 1'b1
    } state_t;

    localparam int ACC_W_DEF  = 8;
    localparam int PERIOD_DEF = 15;

    function automatic int sat_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int sat_min(input int w);
        return -(1 << (w - 1));
    endfunction

endpackage

// File: rtl/iq_accum_lane.sv
// One signed saturating accumulator lane with a sticky per-period saturation flag.
// Also exposes the next sum and flag, so the top can register the final chip's result at a dump.
module iq_accum_lane
    import integrate_dump_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    load,
    input  logic                    add,
    input  logic        [1:0]       din,
    output logic signed [ACC_W-1:0] sum_nxt,
    output logic                    sat_nxt
);

    localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'(sat_max(ACC_W));
    localparam logic [ACC_W-1:0] SAT_MIN = ACC_W'(sat_min(ACC_W));

    logic signed [ACC_W-1:0] acc;
    logic                    sat_flag;
    logic signed [ACC_W:0]   sum_wide;
    logic                    ovf;

    assign sum_wide = {acc[ACC_W-1], acc} + {{(ACC_W-1){din[1]}}, din};
    // The top two bits disagree only when the add left the ACC_W-bit range.
    assign ovf      = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    assign sum_nxt  = ovf ? (sum_wide[ACC_W] ? SAT_MIN : SAT_MAX) : sum_wide[ACC_W-1:0];
    assign sat_nxt  = sat_flag | ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            sat_flag <= 1'b0;
        end else if (clr) begin
            acc      <= '0;
            sat_flag <= 1'b0;
        end else if (load) begin
            acc      <= {{(ACC_W-2){din[1]}}, din};
            sat_flag <= 1'b0;
        end else if (add) begin
            acc      <= sum_nxt;
            sat_flag <= sat_nxt;
        end
    end

endmodule

// File: rtl/integrate_dump.sv
// Integrate-and-dump stage: accumulates despread I/Q chips over one code period aligned to epoch.
// It registers one saturated sum pair per period, together with a one-cycle valid strobe.
//
// state      | meaning
// WAIT_EPOCH | idle; chips ignored until an enabled epoch chip arrives
// INTEGRATE  | accumulating; dump after PERIOD chips, reload on a misaligned epoch
module integrate_dump
    import integrate_dump_pkg::*;
#(
    parameter int PERIOD = PERIOD_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic        [1:0]       I_in,
    input  logic        [1:0]       Q_in,
    input  logic                    epoch,
    input  logic                    clr,
    output logic signed [ACC_W-1:0] I_acc,
    output logic signed [ACC_W-1:0] Q_acc,
    output logic                    dump_valid,
    output logic                    sat
);

    localparam int CNT_W = $clog2(PERIOD + 1);

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic                    chip;
    logic                    slip;
    logic                    dump_fire;
    logic                    lane_clr;
    logic                    lane_load;
    logic                    lane_add;
    logic signed [ACC_W-1:0] i_nxt;
    logic signed [ACC_W-1:0] q_nxt;
    logic                    i_sat_nxt;
    logic                    q_sat_nxt;

    assign chip      = en & ~clr;
    // An epoch mid-period means the code slipped: drop the partial sum and restart.
    assign slip      = chip & epoch & (state == INTEGRATE) & (cnt != '0);
    assign dump_fire = chip & (state == INTEGRATE) & ~slip & (cnt == CNT_W'(PERIOD - 1));
    assign lane_clr  = clr | dump_fire;
    assign lane_load = (chip & epoch & (state == WAIT_EPOCH)) | slip;
    assign lane_add  = chip & (state == INTEGRATE) & ~slip;

    iq_accum_lane #(.ACC_W(ACC_W)) u_lane_i (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (lane_clr),
        .load    (lane_load),
        .add     (lane_add),
        .din     (I_in),
        .sum_nxt (i_nxt),
        .sat_nxt (i_sat_nxt)
    );

    iq_accum_lane #(.ACC_W(ACC_W)) u_lane_q (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (lane_clr),
        .load    (lane_load),
        .add     (lane_add),
        .din     (Q_in),
        .sum_nxt (q_nxt),
        .sat_nxt (q_sat_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= WAIT_EPOCH;
            cnt        <= '0;
            I_acc      <= '0;
            Q_acc      <= '0;
            sat        <= 1'b0;
            dump_valid <= 1'b0;
        end else begin
            dump_valid <= 1'b0;
            if (clr) begin
                state <= WAIT_EPOCH;
                cnt   <= '0;
            end else if (en) begin
                case (state)
                    WAIT_EPOCH: begin
                        if (epoch) begin
                            state <= INTEGRATE;
                            cnt   <= CNT_W'(1);
                        end
                    end
                    INTEGRATE: begin
                        if (slip) begin
                            cnt <= CNT_W'(1);
                        end else if (dump_fire) begin
                            cnt        <= '0;
                            I_acc      <= i_nxt;
                            Q_acc      <= q_nxt;
                            sat        <= i_sat_nxt | q_sat_nxt;
                            dump_valid <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= WAIT_EPOCH;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule
